// File: rtl/bcd_scroll_display.sv
// Purpose : 4-digit multiplexed seven-segment driver for a signed 5-digit BCD value, 3-digit scrolling window.
// Latency : anode/seg registered, one cycle behind stored data / scan index; load/scroll visible next cycle.
// Backpr. : none; load and button levels are sampled every cycle, nothing is ever stalled.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   bcd          20-bit packed BCD, digit k = bcd[4k+3:4k]
//   is_negative  sign captured with bcd
//   load         level, captures bcd/is_negative and returns window to offset 0
//   scroll_left  button level, rising edge moves window toward more-significant digits
//   scroll_right button level, rising edge moves window toward less-significant digits
//   anode        active-low digit enables, anode[3] leftmost (sign position)
//   seg          active-low segments {g,f,e,d,c,b,a}
//   offset       window position 0..2
//
// Optional: define BCD_SCROLL_LZB_EN to blank leading zeros above the highest nonzero digit.
module bcd_scroll_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] bcd,
  input  logic        is_negative,
  input  logic        load,
  input  logic        scroll_left,
  input  logic        scroll_right,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [1:0]  offset
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic [19:0]      r_bcd;
  logic             r_neg;
  logic [1:0]       r_offset;
  logic             r_left_q;
  logic             r_right_q;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_scan;
  logic [3:0]       r_anode;
  logic [6:0]       r_seg;

  logic             w_left_evt;
  logic             w_right_evt;
  logic [1:0]       w_offset_nxt;
  logic [2:0]       w_idx;
  logic [3:0]       w_digit;
  logic [3:0]       w_anode_nxt;
  logic [6:0]       w_seg_nxt;
`ifdef BCD_SCROLL_LZB_EN
  logic [2:0]       w_top;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Rising-edge events: current level against last cycle's level.
  assign w_left_evt  = scroll_left  & ~r_left_q;
  assign w_right_evt = scroll_right & ~r_right_q;

  always_comb begin
    w_offset_nxt = r_offset;
    if (load) begin
      w_offset_nxt = 2'd0;
    end else if (w_left_evt && !w_right_evt) begin
      if (r_offset < 2'd2) w_offset_nxt = r_offset + 2'd1;
    end else if (w_right_evt && !w_left_evt) begin
      if (r_offset > 2'd0) w_offset_nxt = r_offset - 2'd1;
    end
  end

  // Position p shows stored digit (offset + p); only meaningful for p < 3.
  assign w_idx = {1'b0, r_offset} + {1'b0, r_scan};

  always_comb begin
    case (w_idx)
      3'd0:    w_digit = r_bcd[3:0];
      3'd1:    w_digit = r_bcd[7:4];
      3'd2:    w_digit = r_bcd[11:8];
      3'd3:    w_digit = r_bcd[15:12];
      3'd4:    w_digit = r_bcd[19:16];
      default: w_digit = 4'd0;
    endcase
  end

`ifdef BCD_SCROLL_LZB_EN
  // Index of the highest nonzero digit; stays 0 for value 0 so digit 0 is never blanked.
  always_comb begin
    w_top = 3'd0;
    for (int k = 1; k < 5; k++) begin
      if (r_bcd[4*k +: 4] != 4'd0) w_top = 3'(k);
    end
  end
`endif

  always_comb begin
    w_anode_nxt = ~(4'b0001 << r_scan);
    if (r_scan == 2'd3) begin
      w_seg_nxt = r_neg ? SEG_MINUS : SEG_BLANK;
    end else begin
      w_seg_nxt = seg7(w_digit);
`ifdef BCD_SCROLL_LZB_EN
      if (w_idx > w_top) w_seg_nxt = SEG_BLANK;
`endif
    end
  end

  // anode and seg are registered together from the same scan index, so they always switch on one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bcd     <= 20'd0;
      r_neg     <= 1'b0;
      r_offset  <= 2'd0;
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
      r_cnt     <= '0;
      r_scan    <= 2'd0;
      r_anode   <= 4'b1111;
      r_seg     <= SEG_BLANK;
    end else begin
      r_left_q  <= scroll_left;
      r_right_q <= scroll_right;
      if (load) begin
        r_bcd <= bcd;
        r_neg <= is_negative;
      end
      r_offset <= w_offset_nxt;
      if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_cnt  <= '0;
        r_scan <= r_scan + 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_anode <= w_anode_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign anode  = r_anode;
  assign seg    = r_seg;
  assign offset = r_offset;

endmodule
